sdram_bus_sequencer: RTL

SDRAM_BUS_SEQUENCER -- requirements
Module: sdram_bus_sequencer

---
 rtl/sdram_bus_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sdram_bus_sequencer.sv
// Turns a read/write burst command into a sequence of 8-bit register writes on a paged register bus.
// Optional feature: define SDRAM_SEQ_BUSY_POLL_EN so that WAIT polls the busy flag instead of running a fixed delay.
module sdram_bus_sequencer #(
  parameter logic [4:0] PAGE        = 5'd1,
  parameter int         WAIT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic [13:0] adr,
  output logic        we,
  output logic [7:0]  dat_w,
  input  logic [7:0]  dat_r,
  output logic        done,
  output logic        err,
  output logic [3:0]  dbg_state
);
  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid may rise at any time and is held by the source until the transfer.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_LOAD = 4'd1, S_SET_LEN = 4'd2, S_SET_ADDR = 4'd3,
    S_WR_IDX = 4'd4, S_WR_B = 4'd5, S_START = 4'd6, S_WAIT = 4'd7,
    S_DONE = 4'd8, S_ERR = 4'd9
  } state_t;

  state_t      state, state_nxt;
  logic        armed;
  logic        rd_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  idx;
  logic [1:0]  bsel;
  logic [31:0] wait_cnt;
  logic [31:0] buf_q [8];
  logic [8:0]  off;

  logic accept, len_ok, last_word, wait_exit;
  assign accept    = cmd_valid && cmd_ready;
  assign len_ok    = (cmd_len != 4'd0) && (cmd_len <= 4'd8);
  assign last_word = ({1'b0, idx} == (len_q - 4'd1));

`ifdef SDRAM_SEQ_BUSY_POLL_EN
  logic unused_dat;
  assign unused_dat = ^{dat_r[7:1], wait_cnt};
  assign wait_exit  = !dat_r[0];
`else
  logic unused_dat;
  assign unused_dat = ^dat_r;
  // WAIT occupies exactly WAIT_CYCLES cycles; the counter starts at 0 on entry.
  assign wait_exit  = (wait_cnt >= 32'(WAIT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = !len_ok ? S_ERR : (cmd_rd ? S_SET_LEN : S_LOAD);
      S_LOAD:     if (wr_valid && last_word) state_nxt = S_SET_LEN;
      S_SET_LEN:  state_nxt = S_SET_ADDR;
      S_SET_ADDR: if (bsel == 2'd3) state_nxt = rd_q ? S_START : S_WR_IDX;
      S_WR_IDX:   state_nxt = S_WR_B;
      S_WR_B:     if (bsel == 2'd3) state_nxt = last_word ? S_START : S_WR_IDX;
      S_START:    state_nxt = S_WAIT;
      S_WAIT:     if (wait_exit) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      S_ERR:      state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      bsel     <= '0;
      wait_cnt <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: if (accept) begin
          rd_q   <= cmd_rd;
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          idx    <= '0;
          bsel   <= '0;
        end
        S_LOAD: if (wr_valid) begin
          buf_q[idx] <= wr_data;
          if (!last_word) idx <= idx + 3'd1;
        end
        S_SET_LEN: begin
          idx  <= '0;
          bsel <= '0;
        end
        S_SET_ADDR: bsel <= bsel + 2'd1;
        S_WR_B: begin
          bsel <= bsel + 2'd1;
          if (bsel == 2'd3 && !last_word) idx <= idx + 3'd1;
        end
        S_START: wait_cnt <= '0;
        S_WAIT:  if (wait_cnt != 32'hFFFF_FFFF) wait_cnt <= wait_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    off   = 9'd0;
    we    = 1'b0;
    dat_w = 8'd0;
    done  = 1'b0;
    err   = 1'b0;
    case (state)
      S_SET_LEN:  begin we = 1'b1; off = 9'd10; dat_w = {4'd0, len_q}; end
      S_SET_ADDR: begin we = 1'b1; off = 9'd1 + {7'd0, bsel}; dat_w = addr_q[{bsel, 3'b000} +: 8]; end
      S_WR_IDX:   begin we = 1'b1; off = 9'd9; dat_w = {5'd0, idx}; end
      S_WR_B:     begin we = 1'b1; off = 9'd5 + {7'd0, bsel}; dat_w = buf_q[idx][{bsel, 3'b000} +: 8]; end
      S_START:    begin we = 1'b1; off = 9'd11; dat_w = {7'd0, rd_q}; end
      S_DONE:     done = 1'b1;
      S_ERR:      err = 1'b1;
      default: ;
    endcase
  end

  assign adr       = {PAGE, off};
  assign cmd_ready = (state == S_IDLE) && armed;
  assign wr_ready  = (state == S_LOAD);
  assign dbg_state = state;
endmodule
